// File: rtl/event_readout_ctrl.sv
// event_readout_ctrl
//   Acquisition / readout sequencer for one ADC channel. Forwards triggers
//   to the capture datapath while idle, buffers the WINDOW-sample waveform
//   and its pulse height, then serialises a framed byte stream
//   (A5, seq, ph_hi, ph_lo, {s_hi, s_lo} x WINDOW, xor checksum) over a
//   valid/ready handshake. Enforces a capture timeout and a post-frame
//   hold-off, and counts completed frames and dropped triggers.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              acquisition enable (level)
//   trig_in             discriminator trigger pulse
//   trig_gate           trigger forwarded to the capture datapath
//   wf_valid, wf_data   capture datapath sample strobe and sample
//   ph_in               pulse height from the capture datapath
//   tx_data, tx_valid   byte stream to the UART transmitter
//   tx_ready            UART transmitter accepts the current byte
//   busy                high whenever not idle
//   evt_count           completed frames (wraps)
//   drop_count          rejected / aborted triggers (saturates)
module event_readout_ctrl #(
   parameter int unsigned WINDOW   = 32,
   parameter int unsigned SAMPLE_W = 14,
   parameter int unsigned HOLDOFF  = 16,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                trig_in,
   output logic                trig_gate,
   input  logic                wf_valid,
   input  logic [SAMPLE_W-1:0] wf_data,
   input  logic [SAMPLE_W-1:0] ph_in,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                busy,
   output logic [15:0]         evt_count,
   output logic [15:0]         drop_count
);

   localparam int unsigned PTR_W     = $clog2(WINDOW);
   localparam int unsigned FRAME_LEN = 2 * WINDOW + 5;
   localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
   localparam int unsigned TMR_W     = $clog2(TIMEOUT + 1);
   localparam int unsigned HLD_W     = $clog2(HOLDOFF + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_SEND,
      ST_HOLD
   } state_t;

   state_t              state;
   logic [PTR_W-1:0]    wr_ptr;
   logic [TMR_W-1:0]    timer;
   logic [HLD_W-1:0]    hold_cnt;
   logic [IDX_W-1:0]    byte_idx;
   logic [7:0]          csum;
   logic [SAMPLE_W-1:0] ph_q;
   logic [SAMPLE_W-1:0] mem [WINDOW];

   logic [IDX_W-1:0]    nidx;
   logic [PTR_W-1:0]    rd_ptr;
   logic [15:0]         rd_word;
   logic [15:0]         ph_word;
   logic [7:0]          csum_nxt;
   logic [7:0]          next_byte;
   logic                cap_done;
   logic                timeout_hit;
   logic                trig_drop;
   logic [16:0]         drop_sum;

   // Reset counts as "not idle" so nothing is forwarded while held in reset.
   assign trig_gate = trig_in & enable & rst_n & (state == ST_IDLE);

   assign cap_done    = wf_valid && (wr_ptr == PTR_LAST);
   assign timeout_hit = (state == ST_CAPTURE) && !cap_done && (timer == TMR_LAST);
   assign trig_drop   = trig_in && enable && (state != ST_IDLE);
   assign drop_sum    = {1'b0, drop_count} + 17'(trig_drop) + 17'(timeout_hit);

   // Byte that follows the one currently presented. Computed from the
   // buffer one transfer ahead so the registered tx_data can advance every
   // cycle. Sample bytes start at index 4: even index = hi, odd = lo.
   always_comb begin
      nidx     = byte_idx + IDX_W'(1);
      rd_ptr   = PTR_W'((nidx - IDX_W'(4)) >> 1);
      rd_word  = 16'(mem[rd_ptr]);
      ph_word  = 16'(ph_q);
      csum_nxt = (byte_idx == '0) ? csum : (csum ^ tx_data);
      if (nidx == IDX_LAST)
         next_byte = csum_nxt;
      else if (nidx == IDX_W'(1))
         next_byte = evt_count[7:0];
      else if (nidx == IDX_W'(2))
         next_byte = ph_word[15:8];
      else if (nidx == IDX_W'(3))
         next_byte = ph_word[7:0];
      else if (!nidx[0])
         next_byte = rd_word[15:8];
      else
         next_byte = rd_word[7:0];
   end

   // Waveform buffer; contents need no reset.
   always_ff @(posedge clk) begin
      if (state == ST_CAPTURE && wf_valid)
         mem[wr_ptr] <= wf_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         timer      <= '0;
         hold_cnt   <= '0;
         byte_idx   <= '0;
         csum       <= '0;
         ph_q       <= '0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         busy       <= 1'b0;
         evt_count  <= '0;
         drop_count <= '0;
      end else begin
         drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];

         unique case (state)
            ST_IDLE: begin
               if (trig_gate) begin
                  state  <= ST_CAPTURE;
                  busy   <= 1'b1;
                  wr_ptr <= '0;
                  timer  <= '0;
               end
            end

            ST_CAPTURE: begin
               timer <= timer + TMR_W'(1);
               if (wf_valid)
                  wr_ptr <= wr_ptr + PTR_W'(1);
               if (cap_done) begin
                  ph_q     <= ph_in;
                  state    <= ST_SEND;
                  tx_valid <= 1'b1;
                  tx_data  <= 8'hA5;
                  byte_idx <= '0;
                  csum     <= '0;
               end else if (timer == TMR_LAST) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            ST_SEND: begin
               if (tx_ready) begin
                  if (byte_idx == IDX_LAST) begin
                     tx_valid  <= 1'b0;
                     evt_count <= evt_count + 16'd1;
                     state     <= ST_HOLD;
                     hold_cnt  <= '0;
                  end else begin
                     byte_idx <= nidx;
                     tx_data  <= next_byte;
                     csum     <= csum_nxt;
                  end
               end
            end

            ST_HOLD: begin
               if (hold_cnt == HLD_LAST) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HLD_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_event_readout_ctrl.sv
// tb_event_readout_ctrl
//   Directed-sequence bench for event_readout_ctrl with randomized sample
//   data, strobe gaps and tx_ready patterns. Expected frames are built from
//   the frame format rules (header, sequence, pulse height, samples, xor).
module tb_event_readout_ctrl;

   localparam int unsigned WINDOW   = 32;
   localparam int unsigned SAMPLE_W = 14;
   localparam int unsigned HOLDOFF  = 16;
   localparam int unsigned TIMEOUT  = 64;
   localparam int unsigned FLEN     = 2 * WINDOW + 5;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                enable = 1'b0;
   logic                trig_in = 1'b0;
   logic                wf_valid = 1'b0;
   logic                tx_ready = 1'b0;
   logic [SAMPLE_W-1:0] wf_data = '0;
   logic [SAMPLE_W-1:0] ph_in = '0;
   logic                trig_gate;
   logic                tx_valid;
   logic                busy;
   logic [7:0]          tx_data;
   logic [15:0]         evt_count;
   logic [15:0]         drop_count;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [7:0]          got[$];
   logic                stall_pend = 1'b0;
   logic [7:0]          stall_data = '0;
   logic                valid_seen = 1'b0;
   int unsigned         ready_mode = 0;

   logic [SAMPLE_W-1:0] smp [WINDOW];
   logic [SAMPLE_W-1:0] exp_ph;
   int unsigned         exp_evt = 0;
   int unsigned         exp_drop = 0;

   event_readout_ctrl #(
      .WINDOW  (WINDOW),
      .SAMPLE_W(SAMPLE_W),
      .HOLDOFF (HOLDOFF),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .trig_in   (trig_in),
      .trig_gate (trig_gate),
      .wf_valid  (wf_valid),
      .wf_data   (wf_data),
      .ph_in     (ph_in),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .evt_count (evt_count),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Byte logger and stall-stability monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            chk("stall_valid_held", 32'(tx_valid), 32'd1);
            chk("stall_data_stable", 32'(tx_data), 32'(stall_data));
         end
         if (tx_valid)
            valid_seen = 1'b1;
         if (tx_valid && tx_ready)
            got.push_back(tx_data);
         stall_pend = tx_valid && !tx_ready;
         stall_data = tx_data;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // Trigger from IDLE, then deliver nvalid samples (optionally with gaps).
   task automatic start_capture(input bit ramp, input int unsigned nvalid, input bit gaps);
      int unsigned n = 0;
      int unsigned ngap = 0;
      trig_in = 1'b1;
      #1 chk("trig_gate_idle", 32'(trig_gate), 32'd1);
      tick();
      trig_in = 1'b0;
      while (n < nvalid) begin
         if (gaps && ngap < 20 && $urandom_range(0, 3) == 0) begin
            wf_valid = 1'b0;
            wf_data  = SAMPLE_W'($urandom);
            ngap++;
         end else begin
            wf_valid = 1'b1;
            wf_data  = ramp ? SAMPLE_W'(n) : SAMPLE_W'($urandom);
            smp[n]   = wf_data;
            n++;
         end
         ph_in = (wf_valid && n == WINDOW) ? exp_ph : SAMPLE_W'($urandom);
         tick();
      end
      if (nvalid == WINDOW) begin
         // extra strobes after the window must not disturb the buffer
         for (int k = 0; k < 2; k++) begin
            wf_valid = 1'b1;
            wf_data  = SAMPLE_W'($urandom);
            ph_in    = SAMPLE_W'($urandom);
            tick();
         end
      end
      wf_valid = 1'b0;
   endtask

   task automatic check_frame();
      logic [7:0] exp_q[$];
      logic [7:0] x;
      int v;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(exp_evt % 256));
      v = int'(exp_ph);
      exp_q.push_back(8'(v / 256));
      exp_q.push_back(8'(v % 256));
      for (int i = 0; i < WINDOW; i++) begin
         v = int'(smp[i]);
         exp_q.push_back(8'(v / 256));
         exp_q.push_back(8'(v % 256));
      end
      x = 8'h00;
      for (int i = 1; i < exp_q.size(); i++)
         x ^= exp_q[i];
      exp_q.push_back(x);
      chk("frame_len", 32'(got.size()), 32'(exp_q.size()));
      if (got.size() == exp_q.size())
         for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("frame_byte[%0d]", i), 32'(got[i]), 32'(exp_q[i]));
   endtask

   // Wait for the frame, injecting dead-time triggers, then check hold-off.
   task automatic collect_frame(input int unsigned n_dead, input int unsigned first_at,
                                input int unsigned step, input bit hold_trig, input bit en_drop);
      int unsigned cyc = 0;
      int unsigned left = n_dead;
      int unsigned at = first_at;
      while (got.size() < FLEN && cyc < 2000) begin
         if (left > 0 && got.size() >= at) begin
            trig_in = 1'b1;
            #1 chk("trig_gate_send", 32'(trig_gate), 32'd0);
            left--;
            at += step;
            exp_drop++;
         end
         if (en_drop && got.size() >= 5)
            enable = 1'b0;
         tick();
         trig_in = 1'b0;
         cyc++;
      end
      chk("frame_complete", 32'(got.size()), 32'(FLEN));
      chk("tx_valid_after_frame", 32'(tx_valid), 32'd0);
      check_frame();
      exp_evt++;
      chk("evt_count", 32'(evt_count), 32'(exp_evt % 65536));
      for (int k = 1; k < HOLDOFF; k++) begin
         if (hold_trig && k == 4) begin
            trig_in = 1'b1;
            #1 chk("trig_gate_holdoff", 32'(trig_gate), 32'd0);
            exp_drop++;
         end
         tick();
         trig_in = 1'b0;
      end
      chk("busy_in_holdoff", 32'(busy), 32'd1);
      tick();
      chk("busy_after_holdoff", 32'(busy), 32'd0);
      chk("drop_count", 32'(drop_count), 32'(exp_drop));
      enable = 1'b1;
   endtask

   task automatic run_event(input bit ramp, input bit gaps, input int unsigned mode,
                            input logic [SAMPLE_W-1:0] ph, input int unsigned n_dead,
                            input int unsigned first_at, input int unsigned step,
                            input bit hold_trig, input bit en_drop);
      got.delete();
      ready_mode = mode;
      exp_ph = ph;
      start_capture(ramp, WINDOW, gaps);
      collect_frame(n_dead, first_at, step, hold_trig, en_drop);
   endtask

   initial begin
      int unsigned cyc;

      // Reset held with random inputs
      ready_mode = 2;
      for (int k = 0; k < 6; k++) begin
         enable   = 1'($urandom);
         trig_in  = 1'($urandom);
         wf_valid = 1'($urandom);
         wf_data  = SAMPLE_W'($urandom);
         ph_in    = SAMPLE_W'($urandom);
         #1;
         chk("rst_tx_valid", 32'(tx_valid), 32'd0);
         chk("rst_tx_data", 32'(tx_data), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_evt_count", 32'(evt_count), 32'd0);
         chk("rst_drop_count", 32'(drop_count), 32'd0);
         chk("rst_trig_gate", 32'(trig_gate), 32'd0);
         tick();
      end
      enable = 1'b0; trig_in = 1'b0; wf_valid = 1'b0;
      rst_n = 1'b1;
      ready_mode = 0;
      tick(); tick();

      // Enable gating: triggers with enable low do nothing
      for (int k = 0; k < 5; k++) begin
         trig_in = 1'b1;
         #1 chk("gate_disabled", 32'(trig_gate), 32'd0);
         tick();
         trig_in = 1'b0;
         tick();
      end
      chk("disabled_busy", 32'(busy), 32'd0);
      chk("disabled_evt", 32'(evt_count), 32'd0);
      chk("disabled_drop", 32'(drop_count), 32'd0);
      enable = 1'b1;

      // Single ramp event, tx_ready always high
      run_event(1'b1, 1'b0, 0, SAMPLE_W'(16'h0123), 0, 0, 0, 1'b0, 1'b0);
      chk("ramp_checksum", 32'(got[FLEN-1]), 32'h22);

      // Same ramp with tx_ready toggling every cycle
      run_event(1'b1, 1'b0, 1, SAMPLE_W'(16'h0123), 0, 0, 0, 1'b0, 1'b0);

      // Dead-time: three triggers during SEND, one during HOLDOFF
      run_event(1'b0, 1'b1, 0, SAMPLE_W'($urandom), 3, 10, 10, 1'b1, 1'b0);

      // Trigger coinciding with the final handshake is dropped
      run_event(1'b0, 1'b0, 0, SAMPLE_W'($urandom), 1, FLEN - 1, 1, 1'b0, 1'b0);

      // Capture timeout: only 10 samples
      got.delete();
      valid_seen = 1'b0;
      ready_mode = 0;
      start_capture(1'b0, 10, 1'b0);
      repeat (TIMEOUT - 11) tick();
      chk("timeout_busy_before", 32'(busy), 32'd1);
      tick();
      chk("timeout_busy_after", 32'(busy), 32'd0);
      exp_drop++;
      chk("timeout_drop", 32'(drop_count), 32'(exp_drop));
      chk("timeout_evt", 32'(evt_count), 32'(exp_evt));
      chk("timeout_no_valid", 32'(valid_seen), 32'd0);
      chk("timeout_no_bytes", 32'(got.size()), 32'd0);
      tick();

      // Next event accepted normally after timeout
      run_event(1'b0, 1'b1, 2, SAMPLE_W'($urandom), 0, 0, 0, 1'b0, 1'b0);

      // Enable dropped mid-SEND: frame still completes
      run_event(1'b0, 1'b0, 2, SAMPLE_W'($urandom), 0, 0, 0, 1'b0, 1'b1);

      // Random events
      for (int e = 0; e < 3; e++)
         run_event(1'b0, 1'b1, 2, SAMPLE_W'($urandom), 0, 0, 0, 1'b0, 1'b0);

      // Reset asserted mid-SEND
      got.delete();
      ready_mode = 0;
      exp_ph = SAMPLE_W'($urandom);
      start_capture(1'b1, WINDOW, 1'b0);
      cyc = 0;
      while (got.size() < 20 && cyc < 200) begin
         tick();
         cyc++;
      end
      chk("midsend_reached", 32'(tx_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_evt", 32'(evt_count), 32'd0);
      chk("async_rst_drop", 32'(drop_count), 32'd0);
      exp_evt = 0;
      exp_drop = 0;
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_tx_valid", 32'(tx_valid), 32'd0);
      run_event(1'b0, 1'b1, 2, SAMPLE_W'($urandom), 0, 0, 0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/event_readout_ctrl.md
Name: event_readout_ctrl

Overview:
- Sequences acquisition and readout for one ADC channel.
- Gates triggers to the waveform capture datapath and buffers the WINDOW-sample waveform it emits, together with its pulse height.
- Serialises each event as a framed byte stream over a valid/ready handshake to the UART transmitter.
- Enforces dead-time and counts accepted and dropped events.

Parameters:
- WINDOW, 32, samples per event captured and sent (power of 2, 4..64)
- SAMPLE_W, 14, ADC sample and pulse-height width (9..16)
- HOLDOFF, 16, idle cycles after a frame before re-arming (>=1)
- TIMEOUT, 64, max cycles in CAPTURE before abort (>WINDOW)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- enable  in  1  acquisition enable, level
- trig_in  in  1  discriminator trigger pulse
- trig_gate  out  1  trigger forwarded to capture datapath
- wf_valid  in  1  capture datapath window-active strobe
- wf_data  in  SAMPLE_W  capture datapath sample
- ph_in  in  SAMPLE_W  pulse height from capture datapath
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  byte valid
- tx_ready  in  1  UART TX accepts byte
- busy  out  1  high in any state other than IDLE
- evt_count  out  16  completed frames, wraps
- drop_count  out  16  rejected/aborted triggers, saturates at 0xFFFF

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state IDLE; tx_valid=0, tx_data=0, busy=0, evt_count=0, drop_count=0, all pointers/counters 0. Reset asserted mid-frame aborts immediately; the partial frame is not resumed.
- trig_gate = trig_in & enable & (state==IDLE), combinational.
- IDLE:
  - Gated trigger -> CAPTURE next edge; wr_ptr=0, timer=0.
  - wf_valid is ignored.
- CAPTURE:
  - Each cycle with wf_valid=1 writes wf_data to buf[wr_ptr] and increments wr_ptr.
  - On the edge writing the WINDOW-th sample: latch ph_in, go to SEND.
  - timer increments every cycle. If timer reaches TIMEOUT before WINDOW samples are written: go to IDLE, drop_count+1, nothing is transmitted.
- SEND:
  - tx_valid=1 from the first cycle in SEND; outputs are registered.
  - Byte order:
    - 0xA5 header
    - evt_count[7:0] (pre-increment value)
    - pulse height hi byte, then lo byte
    - for i=0..WINDOW-1: sample[i] hi byte, then lo byte
    - checksum
  - Hi byte = zero-extended bits [SAMPLE_W-1:8]; lo byte = bits [7:0].
  - Checksum = XOR of all bytes after the header, up to the last sample byte.
  - Frame length = 2*WINDOW+5 bytes (69 at default).
  - A byte transfers on a cycle with tx_valid&tx_ready. tx_data must remain stable while tx_valid=1 and tx_ready=0. tx_valid never drops mid-frame.
  - On transfer of the checksum byte: tx_valid=0 next cycle, evt_count+1, go to HOLDOFF.
- HOLDOFF: count HOLDOFF cycles, then IDLE.
- Drop counting:
  - trig_in=1 & enable=1 in any state other than IDLE -> drop_count+1 per cycle asserted, saturating.
  - A trigger in the same cycle as the final handshake counts as dropped.
  - trig_in with enable=0 is neither gated nor counted.
- Deasserting enable mid-event does not abort CAPTURE or SEND.
- wf_valid pulses after the WINDOW-th sample are ignored.
- busy=1 in CAPTURE, SEND, HOLDOFF.
- Buffer is a WINDOW x SAMPLE_W register array or inferred RAM. Read latency is hidden so the byte rate is one per cycle when tx_ready=1.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0, trig_gate=0. Assert rst_n=0 mid-SEND -> tx_valid falls without waiting for clk; after release, state is IDLE.
- Single event, default params, enable=1, tx_ready=1: one trig_in, wf_data ramps 0..31 over 32 wf_valid cycles, ph_in=0x0123 -> 69 bytes A5,00,01,23,00,00,00,01,...,00,1F, checksum 0x22; evt_count=1; busy low HOLDOFF cycles after the last byte.
- Backpressure: same event with tx_ready toggling every cycle -> identical 69-byte sequence, tx_data stable during every stall, no byte duplicated or skipped.
- Dead-time: 3 single-cycle trig_in pulses during SEND plus 1 during HOLDOFF -> trig_gate stays 0, drop_count=4. A second event after IDLE carries sequence byte 0x01.
- Capture timeout: trigger followed by only 10 wf_valid cycles -> IDLE after 64 cycles, drop_count=1, tx_valid never asserted, evt_count unchanged. Next trigger is accepted normally.
- Enable gating: enable=0 with 5 triggers -> no trig_gate, counters unchanged. Drop enable during SEND -> frame still completes.
